// File: rtl/credit_dispenser.sv
// Credit dispenser: a saturating credit balance fed by loads and drained by
// withdrawal requests, each answered by a one-deep grant with a shortfall flag.
module credit_dispenser #(
  parameter int BAL_W = 16,
  parameter int AMT_W = 8   // must not exceed BAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [BAL_W-1:0] load_value,
  output logic             load_ready,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             grant_valid,
  output logic [AMT_W-1:0] grant_amt,
  output logic             grant_short,
  input  logic             grant_ready,
  output logic [BAL_W-1:0] balance,
  output logic [7:0]       short_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [BAL_W-1:0] balance_d;
  logic             grant_valid_d, grant_short_d;
  logic [AMT_W-1:0] grant_amt_d;
  logic [7:0]       short_cnt_d;

  logic             load_acc, req_acc, gnt_acc, is_short;
  logic [BAL_W-1:0] req_ext, g, load_add;

  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
  endfunction

  // Handshake readiness comes from state alone, never from inputs.
  assign load_ready = (state_q != GRANT);
  assign req_ready  = (state_q == ACTIVE);

  assign load_acc = load_valid && load_ready;
  assign req_acc  = req_valid && req_ready;
  assign gnt_acc  = grant_valid && grant_ready;

  // g <= balance by construction, so balance - g never wraps, and g <= req_amt
  // so it always fits in AMT_W bits.
  assign req_ext  = BAL_W'(req_amt);
  assign is_short = req_ext > balance;
  assign g        = is_short ? balance : req_ext;
  assign load_add = load_acc ? load_value : '0;

  always_comb begin
    state_d       = state_q;
    balance_d     = balance;
    grant_valid_d = grant_valid;
    grant_amt_d   = grant_amt;
    grant_short_d = grant_short;
    short_cnt_d   = short_cnt;
    case (state_q)
      IDLE: begin
        if (load_acc) begin
          balance_d = sat_add(balance, load_value);
          if (load_value != '0) state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (req_acc) begin
          // Grant sized from the pre-edge balance; a same-edge load lands after.
          balance_d     = sat_add(balance - g, load_add);
          grant_valid_d = 1'b1;
          grant_amt_d   = g[AMT_W-1:0];
          grant_short_d = is_short;
          if (is_short && short_cnt != 8'hFF) short_cnt_d = short_cnt + 8'd1;
          state_d       = GRANT;
        end else if (load_acc) begin
          balance_d = sat_add(balance, load_value);
        end
      end
      GRANT: begin
        if (gnt_acc) begin
          grant_valid_d = 1'b0;
          state_d       = (balance == '0) ? IDLE : ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      balance     <= '0;
      grant_valid <= 1'b0;
      grant_amt   <= '0;
      grant_short <= 1'b0;
      short_cnt   <= 8'h00;
    end else begin
      state_q     <= state_d;
      balance     <= balance_d;
      grant_valid <= grant_valid_d;
      grant_amt   <= grant_amt_d;
      grant_short <= grant_short_d;
      short_cnt   <= short_cnt_d;
    end
  end

endmodule

// File: tb/tb_credit_dispenser.sv
// Bench for credit_dispenser: abstract balance/pending-grant model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_credit_dispenser;
  localparam int BAL_W = 16;
  localparam int AMT_W = 8;
  localparam int BAL_MAX = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic [BAL_W-1:0] load_value = '0;
  logic             load_ready;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             req_ready;
  logic             grant_valid;
  logic [AMT_W-1:0] grant_amt;
  logic             grant_short;
  logic             grant_ready = 1'b0;
  logic [BAL_W-1:0] balance;
  logic [7:0]       short_cnt;

  int checks = 0;
  int errors = 0;

  credit_dispenser #(.BAL_W(BAL_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .grant_valid(grant_valid), .grant_amt(grant_amt), .grant_short(grant_short),
    .grant_ready(grant_ready), .balance(balance), .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a balance and an optional pending grant. No pending grant and zero
  // balance is the empty state; credit is withdrawable only with no grant pending.
  int m_bal = 0, m_ga = 0, m_sc = 0;
  bit m_pend = 0, m_gs = 0;

  initial begin
    bit la, ra, gc;
    int g, nb;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_bal = 0; m_pend = 0; m_ga = 0; m_gs = 0; m_sc = 0;
      end else begin
        la = load_valid && !m_pend;
        ra = req_valid && !m_pend && (m_bal > 0);
        gc = m_pend && grant_ready;
        if (ra) begin
          g  = (int'(req_amt) < m_bal) ? int'(req_amt) : m_bal;
          nb = m_bal - g + (la ? int'(load_value) : 0);
          m_bal  = (nb > BAL_MAX) ? BAL_MAX : nb;
          m_pend = 1; m_ga = g; m_gs = int'(req_amt) > (m_bal + g - (la ? int'(load_value) : 0)) ? 1'b1 : 1'b0;
          if (m_gs && m_sc < 255) m_sc++;
        end else if (la) begin
          nb = m_bal + int'(load_value);
          m_bal = (nb > BAL_MAX) ? BAL_MAX : nb;
        end
        if (gc) m_pend = 0;
      end
      #1;
      chk("balance", 32'(balance), 32'(m_bal));
      chk("grant_valid", 32'(grant_valid), 32'(m_pend));
      chk("grant_amt", 32'(grant_amt), 32'(m_ga));
      chk("grant_short", 32'(grant_short), 32'(m_gs));
      chk("short_cnt", 32'(short_cnt), 32'(m_sc));
      chk("load_ready", 32'(load_ready), 32'(!m_pend));
      chk("req_ready", 32'(req_ready), 32'(!m_pend && m_bal > 0));
    end
  end

  task automatic do_load(input logic [BAL_W-1:0] v);
    @(negedge clk); load_valid = 1'b1; load_value = v;
    @(negedge clk); load_valid = 1'b0;
  endtask

  task automatic do_req(input logic [AMT_W-1:0] a);
    @(negedge clk); req_valid = 1'b1; req_amt = a;
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk); grant_ready = 1'b1;
    @(negedge clk); grant_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_balance", 32'(balance), 32'h0);
    chk("rst_grant_valid", 32'(grant_valid), 32'h0);
    chk("rst_short_cnt", 32'(short_cnt), 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    #1;
    chk("post_rst_load_ready", 32'(load_ready), 32'h1);
    chk("post_rst_req_ready", 32'(req_ready), 32'h0);

    // Zero load stays empty
    do_load(16'h0000);
    chk("zero_load_req_ready", 32'(req_ready), 32'h0);

    // Load 0x10, request 5
    do_load(16'h0010);
    do_req(8'h05);
    chk("r34_grant_valid", 32'(grant_valid), 32'h1);
    chk("r34_grant_amt", 32'(grant_amt), 32'h5);
    chk("r34_grant_short", 32'(grant_short), 32'h0);
    chk("r34_balance", 32'(balance), 32'h000B);
    consume();
    chk("r34_active_req_ready", 32'(req_ready), 32'h1);

    // Drain to 3, then over-request
    do_req(8'h08); consume();
    chk("bal_3", 32'(balance), 32'h3);
    do_req(8'h0A);
    chk("r35_grant_amt", 32'(grant_amt), 32'h3);
    chk("r35_grant_short", 32'(grant_short), 32'h1);
    chk("r35_balance", 32'(balance), 32'h0);
    chk("r35_short_cnt", 32'(short_cnt), 32'h1);
    consume();
    chk("r35_req_ready", 32'(req_ready), 32'h0);
    chk("r35_load_ready", 32'(load_ready), 32'h1);

    // Saturation
    do_load(16'hFFF0);
    do_load(16'h0100);
    chk("r36_sat", 32'(balance), 32'hFFFF);
    do_load(16'h0001);
    chk("r36_sat_hold", 32'(balance), 32'hFFFF);

    // Simultaneous load and request
    pulse_reset();
    do_load(16'h0008);
    @(negedge clk); load_valid = 1'b1; load_value = 16'h0004; req_valid = 1'b1; req_amt = 8'h08;
    @(negedge clk); load_valid = 1'b0; req_valid = 1'b0;
    chk("r37_grant_amt", 32'(grant_amt), 32'h8);
    chk("r37_grant_short", 32'(grant_short), 32'h0);
    chk("r37_balance", 32'(balance), 32'h0004);
    consume();

    // Zero-amount request
    do_req(8'h00);
    chk("r25_grant_valid", 32'(grant_valid), 32'h1);
    chk("r25_grant_amt", 32'(grant_amt), 32'h0);
    chk("r25_balance", 32'(balance), 32'h4);
    consume();

    // Held grant, competing inputs ignored, then async reset mid-hold
    do_req(8'h02);
    load_valid = 1'b1; load_value = 16'h0007; req_valid = 1'b1; req_amt = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r38_hold_valid", 32'(grant_valid), 32'h1);
      chk("r38_hold_amt", 32'(grant_amt), 32'h2);
      chk("r38_hold_balance", 32'(balance), 32'h2);
      chk("r38_load_ready", 32'(load_ready), 32'h0);
      chk("r38_req_ready", 32'(req_ready), 32'h0);
    end
    load_valid = 1'b0; req_valid = 1'b0;
    #2; rst = 1'b0; #1;
    chk("r38_rst_valid", 32'(grant_valid), 32'h0);
    chk("r38_rst_amt", 32'(grant_amt), 32'h0);
    chk("r38_rst_balance", 32'(balance), 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b1;

    // Grant consumed in the cycle it first appears
    do_load(16'h0005);
    @(negedge clk); req_valid = 1'b1; req_amt = 8'h01; grant_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    chk("r28_presented", 32'(grant_valid), 32'h1);
    @(negedge clk); grant_ready = 1'b0;
    chk("r28_done", 32'(grant_valid), 32'h0);
    chk("r28_balance", 32'(balance), 32'h4);

    // 260 short grants saturate the counter
    pulse_reset();
    grant_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); load_valid = 1'b1; load_value = 16'h0001;
      @(negedge clk); load_valid = 1'b0; req_valid = 1'b1; req_amt = 8'h02;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      if (i == 9) chk("r39_cnt10", 32'(short_cnt), 32'd10);
    end
    grant_ready = 1'b0;
    chk("r39_sat", 32'(short_cnt), 32'hFF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_dispenser.md
CREDIT_DISPENSER -- requirements
Module: credit_dispenser

Interface
REQ-001 Parameters SHALL be: BAL_W, 16, balance width; AMT_W, 8, request/grant width.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load_valid  input  1  load request.
REQ-005 load_value  input  BAL_W  credit to add.
REQ-006 load_ready  output  1  load accepted when load_valid && load_ready.
REQ-007 req_valid  input  1  withdrawal request.
REQ-008 req_amt  input  AMT_W  amount requested.
REQ-009 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-010 grant_valid  output  1  grant pending.
REQ-011 grant_amt  output  AMT_W  amount granted.
REQ-012 grant_short  output  1  grant smaller than the request.
REQ-013 grant_ready  input  1  grant consumed when grant_valid && grant_ready.
REQ-014 balance  output  BAL_W  current credit, registered.
REQ-015 short_cnt  output  8  count of short grants, registered.

Function
REQ-016 FSM states SHALL be IDLE (balance 0), ACTIVE (credit available), and GRANT (grant pending).
REQ-017 load_ready SHALL be 1 in IDLE and ACTIVE and 0 in GRANT.
REQ-018 req_ready SHALL be 1 only in ACTIVE; it SHALL NOT depend combinationally on any input.
REQ-019 Load accept: balance SHALL become min(balance + load_value, 2^BAL_W-1), using a BAL_W+1-bit sum with carry forcing all-ones.
REQ-020 Load in IDLE with load_value != 0 SHALL move to ACTIVE next cycle; a zero load SHALL stay in IDLE.
REQ-021 Request accept in ACTIVE: g = min(req_amt, balance); grant_amt <= g; grant_short <= (req_amt > balance); grant_valid <= 1; state SHALL move to GRANT.
REQ-022 The balance decrement SHALL occur on the accept edge, so balance already shows the reduced value when grant_valid first rises.
REQ-023 Grant latency SHALL be exactly 1 cycle: request accepted at edge N gives grant_valid = 1 after edge N.
REQ-024 Simultaneous load and request accept in ACTIVE: g SHALL use the pre-edge balance, and the new balance SHALL be sat(balance - g + load_value).
REQ-025 req_amt = 0 SHALL produce a normal handshake with grant_amt 0 and grant_short 0.
REQ-026 grant_amt and grant_short SHALL hold stable while grant_valid && !grant_ready.
REQ-027 Grant consume: grant_valid <= 0; next state SHALL be IDLE if balance == 0, else ACTIVE.
REQ-028 A grant with grant_valid && grant_ready in the same cycle it is presented SHALL complete in one GRANT cycle.
REQ-029 short_cnt SHALL increment on each accepted request with grant_short set, and SHALL saturate at 8'hFF without wrap.
REQ-030 Balance SHALL never underflow; the subtraction result SHALL always be >= 0 by construction of g.

Reset
REQ-031 When rst = 0, asynchronously: state = IDLE, balance = 0, grant_valid = 0, grant_amt = 0, grant_short = 0, short_cnt = 0.
REQ-032 Reset asserted during GRANT SHALL drop the pending grant with no consume required.
REQ-033 After reset deassertion, load_ready = 1 and req_ready = 0.

Verification
REQ-034 Load 16'h0010, then request 8'h05 -> one cycle later grant_amt = 5, grant_short = 0, balance = 16'h000B; after consume, state is ACTIVE.
REQ-035 Balance 3, request 8'h0A -> grant_amt = 3, grant_short = 1, balance = 0, short_cnt += 1; after consume, state is IDLE and req_ready = 0.
REQ-036 Balance 16'hFFF0, load 16'h0100 -> balance = 16'hFFFF (saturated); a following load of 1 keeps 16'hFFFF.
REQ-037 Balance 16'h0008, request 8'h08 and load 16'h0004 accepted same edge -> grant_amt = 8, grant_short = 0, balance = 16'h0004.
REQ-038 Grant held with grant_ready = 0 for 5 cycles -> outputs stable, load_ready = 0, req_ready = 0; rst pulse low mid-hold -> all outputs zero immediately.
REQ-039 Issue 260 short grants -> short_cnt = 8'hFF.
